pagerank_gather: RTL and testbench

Gather stage of the PageRank engine. It sits directly downstream of the scatter stage and consumes its (node_id, contribution) stream with no backpressure, summing contributions into one accumulator per graph node. When the scatter stage signals completion, it applies damping, `rank_new = BASE + DAMPING·acc`, to each node in turn. The results drive the `page_rank_old` inputs of the next iteration.

---
 rtl/pagerank_gather.sv | 93 +++++++++
 tb/tb_pagerank_gather.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pagerank_gather.sv
// pagerank_gather: accumulates scatter contributions per node, then applies damping (optional saturation via PAGERANK_GATHER_SAT_EN)
module pagerank_gather #(
  parameter int          NODES_IN_GRAPH = 32,
  parameter logic [15:0] DAMPING        = 16'd55706,
  parameter logic [63:0] BASE_TERM      = 64'h0000_0000_04CC_CCCD,
  parameter logic [63:0] INIT_RANK      = 64'h0000_0000_0800_0000
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               gather_enable,
  input  logic                               in_valid,
  input  logic [31:0]                        in_node_id,
  input  logic [63:0]                        in_contrib,
  input  logic                               scatter_done,
  input  logic                               next_iteration,
  output logic [NODES_IN_GRAPH-1:0][63:0]    page_rank_new,
  output logic                               iteration_done,
  output logic                               busy,
  output logic [15:0]                        drop_count
);
  localparam int KW = NODES_IN_GRAPH > 1 ? $clog2(NODES_IN_GRAPH) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, APPLY, DONE} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k;
  logic [63:0] acc [NODES_IN_GRAPH];
  logic [KW-1:0] idx;
  logic in_range, hit, drop, apply_en, last;
  logic [63:0] acc_w, scaled, rank_w;
`ifdef PAGERANK_GATHER_SAT_EN
  logic [64:0] acc_sum, rank_sum;
`endif
  // datapath: accumulate sum, damped rank and sample classification
  always_comb begin
    idx      = in_node_id[KW-1:0];
    in_range = in_node_id < 32'(NODES_IN_GRAPH);
    hit      = gather_enable && in_valid && state == ACCUM && in_range;
    drop     = gather_enable && in_valid && (state == ACCUM ? !in_range : state != IDLE);
    apply_en = gather_enable && state == APPLY;
    last     = k == KW'(NODES_IN_GRAPH - 1);
    scaled   = 64'(({16'b0, acc[k]} * {64'b0, DAMPING}) >> 16);
`ifdef PAGERANK_GATHER_SAT_EN
    acc_sum  = {1'b0, acc[idx]} + {1'b0, in_contrib};
    rank_sum = {1'b0, BASE_TERM} + {1'b0, scaled};
    acc_w    = acc_sum[64] ? '1 : acc_sum[63:0];
    rank_w   = rank_sum[64] ? '1 : rank_sum[63:0];
`else
    acc_w    = acc[idx] + in_contrib;
    rank_w   = BASE_TERM + scaled;
`endif
  end
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // next-state logic; everything holds while disabled
  always_comb begin
    state_nx = state;
    if (gather_enable)
      case (state)
        IDLE:    state_nx = ACCUM;
        ACCUM:   state_nx = scatter_done ? APPLY : ACCUM;
        APPLY:   state_nx = last ? DONE : APPLY;
        default: state_nx = next_iteration ? ACCUM : DONE;
      endcase
  end
  // state-decoded outputs
  always_comb busy = state == APPLY;
  // apply index: counts through APPLY, parked at zero otherwise
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) k <= '0;
    else if (gather_enable) k <= state == APPLY && !last ? k + 1'b1 : '0;
  // done flag rises one edge after the last rank write, falls on leaving DONE
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) iteration_done <= 1'b0;
    else if (gather_enable) iteration_done <= state == DONE && !next_iteration;
  // saturating count of discarded contributions
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  // accumulators: add in ACCUM, clear as each node is applied
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NODES_IN_GRAPH; i++) acc[i] <= '0;
    else
      for (int i = 0; i < NODES_IN_GRAPH; i++)
        if (apply_en && k == KW'(i)) acc[i] <= '0;
        else if (hit && in_node_id == 32'(i)) acc[i] <= acc_w;
  // rank array written one node per apply cycle
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < NODES_IN_GRAPH; i++) page_rank_new[i] <= INIT_RANK;
    else
      for (int i = 0; i < NODES_IN_GRAPH; i++)
        if (apply_en && k == KW'(i)) page_rank_new[i] <= rank_w;
endmodule

// File: tb/tb_pagerank_gather.sv
// tb_pagerank_gather: directed self-checking bench for pagerank_gather (N=4, d=0.5)
module tb_pagerank_gather;
  localparam logic [63:0] INIT = 64'h0000_0000_0800_0000;
  localparam logic [63:0] BASE = 64'h1000_0000;
`ifdef PAGERANK_GATHER_SAT_EN
  localparam logic [63:0] OVF = 64'h8000_0000_0FFF_FFFF;
`else
  localparam logic [63:0] OVF = 64'h7FFF_FFFF_1000_0000;
`endif
  logic clock = 0, reset_n = 0, gather_enable = 0, in_valid = 0, scatter_done = 0, next_iteration = 0;
  logic [31:0] in_node_id = 0;
  logic [63:0] in_contrib = 0;
  logic [3:0][63:0] page_rank_new;
  logic iteration_done, busy;
  logic [15:0] drop_count;
  int n_checks = 0, n_fail = 0;
  pagerank_gather #(.NODES_IN_GRAPH(4), .DAMPING(16'd32768), .BASE_TERM(BASE), .INIT_RANK(INIT)) dut (
    .clock(clock), .reset_n(reset_n), .gather_enable(gather_enable), .in_valid(in_valid),
    .in_node_id(in_node_id), .in_contrib(in_contrib), .scatter_done(scatter_done),
    .next_iteration(next_iteration), .page_rank_new(page_rank_new),
    .iteration_done(iteration_done), .busy(busy), .drop_count(drop_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic sample(input logic [31:0] id, input logic [63:0] c, input logic sd);
    in_valid = 1; in_node_id = id; in_contrib = c; scatter_done = sd;
    tick;
    in_valid = 0; scatter_done = 0;
  endtask
  task automatic check_ranks(input string tag, input logic [63:0] r0, r1, r2, r3);
    check({tag, "_r0"}, page_rank_new[0], r0);
    check({tag, "_r1"}, page_rank_new[1], r1);
    check({tag, "_r2"}, page_rank_new[2], r2);
    check({tag, "_r3"}, page_rank_new[3], r3);
  endtask
  initial begin
    #12;
    check_ranks("reset", INIT, INIT, INIT, INIT);
    check("reset_drop", 64'(drop_count), 0);
    check("reset_done", 64'(iteration_done), 0);
    check("reset_busy", 64'(busy), 0);
    tick;
    reset_n = 1;
    gather_enable = 1;
    tick;
    sample(1, 64'h2000_0000, 0);
    sample(1, 64'h2000_0000, 0);
    sample(7, 64'h1234, 0);
    check("oor_drop", 64'(drop_count), 1);
    scatter_done = 1;
    tick;
    scatter_done = 0;
    check("apply_busy", 64'(busy), 1);
    sample(0, 64'h5555_0000, 0);
    repeat (3) tick;
    check("done_not_early", 64'(iteration_done), 0);
    tick;
    check("done_rise", 64'(iteration_done), 1);
    check("done_busy", 64'(busy), 0);
    check_ranks("basic", BASE, 64'h3000_0000, BASE, BASE);
    check("late_drop", 64'(drop_count), 2);
    next_iteration = 1;
    tick;
    next_iteration = 0;
    check("done_fall", 64'(iteration_done), 0);
    sample(0, 64'h4000_0000, 0);
    sample(2, 64'hFFFF_FFFF_0000_0000, 0);
    sample(2, 64'hFFFF_FFFF_0000_0000, 1);
    repeat (5) tick;
    check("iter2_done", 64'(iteration_done), 1);
    check_ranks("iter2", 64'h3000_0000, BASE, OVF, BASE);
    next_iteration = 1;
    tick;
    next_iteration = 0;
    sample(1, 64'h1000_0000, 0);
    sample(3, 64'h6000_0000, 1);
    tick;
    gather_enable = 0;
    in_valid = 1; in_node_id = 0; in_contrib = 64'h7;
    repeat (3) tick;
    in_valid = 0;
    check("freeze_r0", page_rank_new[0], BASE);
    check("freeze_r1", page_rank_new[1], BASE);
    check("freeze_busy", 64'(busy), 1);
    check("freeze_drop", 64'(drop_count), 2);
    gather_enable = 1;
    tick;
    check("resume_r1", page_rank_new[1], 64'h1800_0000);
    check("resume_r2_old", page_rank_new[2], OVF);
    tick;
    check("resume_r2", page_rank_new[2], BASE);
    check("resume_r3_old", page_rank_new[3], BASE);
    tick;
    check("resume_r3", page_rank_new[3], 64'h4000_0000);
    check("resume_done_early", 64'(iteration_done), 0);
    tick;
    check("resume_done", 64'(iteration_done), 1);
    next_iteration = 1;
    tick;
    next_iteration = 0;
    sample(0, 64'h4000_0000, 0);
    reset_n = 0;
    #2;
    check_ranks("midreset", INIT, INIT, INIT, INIT);
    check("midreset_drop", 64'(drop_count), 0);
    check("midreset_busy", 64'(busy), 0);
    tick;
    reset_n = 1;
    tick;
    scatter_done = 1;
    tick;
    scatter_done = 0;
    repeat (5) tick;
    check("postreset_done", 64'(iteration_done), 1);
    check_ranks("postreset", BASE, BASE, BASE, BASE);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
